alu_bist_ctrl: RTL and testbench
================================

// Module: alu_bist_ctrl
// PURPOSE
//  Built-in self-test controller for the ALU. Drives alu_src0/alu_src1/alu_op,
//  sweeps every opcode in [OP_FIRST..OP_LAST] one per cycle and reads back alu_res.
//  Compacts the results into a 32-bit MISR signature. Sits between the top-level
//  test/debug logic and the combinational ALU.
// PARAMETERS
//  OP_FIRST  5'd0            first opcode driven in a sweep
//  OP_LAST   5'd31           last opcode driven; OP_LAST >= OP_FIRST is required
//  SEED      32'h0000_0001   MISR value loaded on start
//  POLY      32'h0040_0007   MISR feedback taps (x^32+x^22+x^2+x+1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  start      in   1   sweep request, sampled in IDLE only
//  abort      in   1   abandon the running sweep
//  src0_init  in   32  operand A, held for the whole sweep
//  src1_init  in   32  operand B, held for the whole sweep
//  exp_sig    in   32  expected signature (used only with ALU_BIST_CMP_EN)
//  alu_src0   out  32  to ALU operand A
//  alu_src1   out  32  to ALU operand B
//  alu_op     out  5   to ALU opcode
//  alu_res    in   32  from ALU (combinational in the same cycle as alu_op)
//  busy       out  1   high in RUN
//  done       out  1   one-cycle pulse on sweep completion
//  signature  out  32  MISR value, held until the next start
//  pass       out  1   signature == exp_sig, sticky until the next start
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: alu_src0/1, alu_op, busy, done, signature, pass.
//  - All ALU-side outputs are registered, so alu_res is sampled in the cycle it is valid.
//  - States:
//    - IDLE: on start=1 (abort=0), load alu_src0/1 <= *_init, alu_op <= OP_FIRST,
//      signature <= SEED, pass <= 0, then go to RUN.
//    - RUN: busy=1. Each cycle, signature <= {sig[30:0],1'b0} ^ (sig[31]?POLY:0) ^ alu_res.
//      If alu_op != OP_LAST: alu_op++. If alu_op == OP_LAST: go to DONE.
//    - DONE: done=1 for exactly one cycle, pass updated, then IDLE.
//      alu_op/alu_src* hold their last values.
//  - Latency: start -> done pulse = (OP_LAST-OP_FIRST+1)+2 cycles
//    (34 with the defaults, counting the start cycle as 1).
//  - alu_op never wraps. An OP_LAST of 31 terminates without overflowing the 5-bit field.
//  - start while in RUN/DONE is ignored. No queueing.
//  - abort in RUN: go to IDLE next cycle, no done pulse, signature frozen, pass=0.
//    abort in IDLE has priority over start. abort in DONE is ignored.
//  - rst mid-sweep: immediate return to the reset values, sweep lost.
// CONFIGURATION
//  - ALU_BIST_CMP_EN defined: in DONE, pass <= (next signature == exp_sig).
//  - ALU_BIST_CMP_EN undefined: pass is tied to 0 and exp_sig is unused;
//    signature alone is the result.
// STRUCTURE
//  - Shared package alu_pkg: ALU opcode width (5), data width (32), default
//    POLY/SEED constants, and the FSM state encoding (IDLE/RUN/DONE).
//  - One sub-module, alu_misr: 32-bit MISR with load/enable/data inputs.
//    The controller FSM and opcode counter stay in alu_bist_ctrl.
// TESTING
//  - Stub ALU alu_res=0, defaults, start pulse -> alu_op steps 0..31 on consecutive
//    cycles, done at cycle 34, signature=32'h0040_0007.
//  - Stub alu_res=0, OP_LAST=30 -> 31 ops, signature=32'h8000_0000,
//    done after 33 cycles.
//  - Real ALU, src0_init=32'h8000ffff, src1_init=32'h1 -> alu_src0/1 match the inits
//    throughout RUN. Bench model signature == DUT signature.
//  - With ALU_BIST_CMP_EN: exp_sig=32'h0040_0007 with the zero stub -> pass=1.
//    exp_sig=0 -> pass=0.
//  - Corner cases:
//    - abort at the 5th RUN cycle -> IDLE next cycle, no done, busy=0.
//    - start during RUN -> ignored, alu_op sequence unchanged.
//  - rst asserted mid-sweep (asynchronously, between edges) -> all outputs 0 at once.
//    A new start after release restarts from OP_FIRST.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/BIST definitions: datapath widths, default MISR constants,
// controller state encoding and the MISR step function.
package alu_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] MISR_POLY_DEF = 32'h0040_0007;
  localparam logic [DATA_W-1:0] MISR_SEED_DEF = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // Galois-style shift with feedback, then fold in the new ALU result.
  function automatic logic [DATA_W-1:0] misr_step(
    input logic [DATA_W-1:0] sig,
    input logic [DATA_W-1:0] poly,
    input logic [DATA_W-1:0] data
  );
    misr_step = {sig[DATA_W-2:0], 1'b0} ^ (sig[DATA_W-1] ? poly : '0) ^ data;
  endfunction

endpackage

// File: rtl/alu_misr.sv
// 32-bit multiple-input signature register: load seeds, enable compacts data.
module alu_misr
  import alu_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = MISR_SEED_DEF,
  parameter logic [DATA_W-1:0] POLY = MISR_POLY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sig,
  output logic [DATA_W-1:0] o_sig_next
);

  logic [DATA_W-1:0] r_sig;
  logic [DATA_W-1:0] w_sig_next;

  always_comb begin
    w_sig_next = r_sig;
    if (i_load)
      w_sig_next = SEED;
    else if (i_en)
      w_sig_next = misr_step(r_sig, POLY, i_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sig <= '0;
    else
      r_sig <= w_sig_next;
  end

  assign o_sig      = r_sig;
  assign o_sig_next = w_sig_next;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU BIST controller: sweeps opcodes OP_FIRST..OP_LAST and compacts alu_res
// into a MISR signature. Define ALU_BIST_CMP_EN to enable the pass comparison.
module alu_bist_ctrl
  import alu_pkg::*;
#(
  parameter logic [OP_W-1:0]   OP_FIRST = 5'd0,
  parameter logic [OP_W-1:0]   OP_LAST  = 5'd31,
  parameter logic [DATA_W-1:0] SEED     = MISR_SEED_DEF,
  parameter logic [DATA_W-1:0] POLY     = MISR_POLY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] src0_init,
  input  logic [DATA_W-1:0] src1_init,
  input  logic [DATA_W-1:0] exp_sig,
  output logic [DATA_W-1:0] alu_src0,
  output logic [DATA_W-1:0] alu_src1,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] signature,
  output logic              pass
);

  bist_state_e       r_state, w_state_next;
  logic              w_load;
  logic              w_step;
  logic [DATA_W-1:0] r_src0, r_src1;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] w_sig_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // abort outranks start in IDLE and stops compaction in RUN
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_op == OP_LAST)
            w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Opcode stops at OP_LAST so a final opcode of 31 never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src0 <= '0;
      r_src1 <= '0;
      r_op   <= '0;
    end else if (w_load) begin
      r_src0 <= src0_init;
      r_src1 <= src1_init;
      r_op   <= OP_FIRST;
    end else if (w_step && (r_op != OP_LAST)) begin
      r_op <= r_op + 5'd1;
    end
  end

  alu_misr #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_misr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_en       (w_step),
    .i_data     (alu_res),
    .o_sig      (signature),
    .o_sig_next (w_sig_next)
  );

`ifdef ALU_BIST_CMP_EN
  logic r_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pass <= 1'b0;
    else if (w_load || (r_state == ST_RUN && abort))
      r_pass <= 1'b0;
    else if (r_state == ST_DONE)
      r_pass <= (w_sig_next == exp_sig);
  end

  assign pass = r_pass;
`else
  logic w_unused_cmp;
  assign w_unused_cmp = ^{exp_sig, w_sig_next};
  assign pass         = 1'b0;
`endif

  assign alu_src0 = r_src0;
  assign alu_src1 = r_src1;
  assign alu_op   = r_op;
  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl: opcode sweep, MISR signature,
// abort, start-in-RUN, async reset and an OP_LAST=30 instance.
module tb_alu_bist_ctrl;

  localparam logic [31:0] POLY = 32'h0040_0007;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, start30 = 1'b0;
  logic [31:0] src0_init = '0, src1_init = '0, exp_sig = '0;
  logic [31:0] alu_src0, alu_src1, alu_res, signature;
  logic [4:0]  alu_op;
  logic        busy, done, pass;
  logic        use_real = 1'b0;

  logic [31:0] src0_30, src1_30, sig30;
  logic [4:0]  op30;
  logic        busy30, done30, pass30;

  int tests = 0;
  int fails = 0;

  logic [4:0]  op_q[$];
  logic [31:0] sig_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op[2:0])
      3'd0:    alu_fn = a + b;
      3'd1:    alu_fn = a - b;
      3'd2:    alu_fn = a & b;
      3'd3:    alu_fn = a | b;
      3'd4:    alu_fn = a ^ b;
      3'd5:    alu_fn = a << b[4:0];
      3'd6:    alu_fn = a >> b[4:0];
      default: alu_fn = {27'd0, op} ^ ~a;
    endcase
  endfunction

  always_comb alu_res = use_real ? alu_fn(alu_op, alu_src0, alu_src1) : 32'h0;

  alu_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src0_init(src0_init), .src1_init(src1_init), .exp_sig(exp_sig),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op), .alu_res(alu_res),
    .busy(busy), .done(done), .signature(signature), .pass(pass)
  );

  alu_bist_ctrl #(.OP_FIRST(5'd0), .OP_LAST(5'd30)) dut30 (
    .clk(clk), .rst(rst), .start(start30), .abort(1'b0),
    .src0_init(32'h0), .src1_init(32'h0), .exp_sig(32'h8000_0000),
    .alu_src0(src0_30), .alu_src1(src1_30), .alu_op(op30), .alu_res(32'h0),
    .busy(busy30), .done(done30), .signature(sig30), .pass(pass30)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_sig(input int unsigned n, input logic [31:0] a,
                                            input logic [31:0] b, input logic real_alu);
    logic [31:0] s;
    logic [4:0]  op;
    s = SEED;
    for (int unsigned i = 0; i < n; i++) begin
      op = i[4:0];
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ (real_alu ? alu_fn(op, a, b) : 32'h0);
    end
    return s;
  endfunction

  // Full 32-op sweep on dut; optionally pokes start mid-RUN.
  task automatic do_sweep(input string tag, input logic poke_start);
    int unsigned cyc;
    logic [31:0] esig;
    logic        epass;
    for (int unsigned i = 0; i < 32; i++) op_q.push_back(i[4:0]);
    esig = model_sig(32, src0_init, src1_init, use_real);
    sig_q.push_back(esig);
`ifdef ALU_BIST_CMP_EN
    epass = (esig == exp_sig);
`else
    epass = 1'b0;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 60) begin
      start = poke_start && (cyc >= 10 && cyc <= 12);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_op"}, {27'd0, alu_op}, (op_q.size() > 0) ? {27'd0, op_q.pop_front()} : 32'hdead);
      chk({tag, "_src0"}, alu_src0, src0_init);
      chk({tag, "_src1"}, alu_src1, src1_init);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, 32'd34);
    chk({tag, "_op_q_empty"}, op_q.size(), 32'd0);
    chk({tag, "_sig"}, signature, sig_q.pop_front());
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, epass});
    chk({tag, "_sig_held"}, signature, esig);
  endtask

  initial begin
    int unsigned cyc;
    #23;
    chk("rst_op", {27'd0, alu_op}, 32'd0);
    chk("rst_src0", alu_src0, 32'd0);
    chk("rst_sig", signature, 32'd0);
    chk("rst_flags", {29'd0, busy, done, pass}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    exp_sig = 32'h0040_0007;
    do_sweep("zero", 1'b0);
    chk("zero_sig_const", signature, 32'h0040_0007);

    exp_sig = 32'h0;
    do_sweep("zero_badexp", 1'b1);

    // OP_LAST = 30 instance
    start30 = 1'b1;
    tick();
    start30 = 1'b0;
    cyc = 2;
    while (done30 !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("op30_done_cycle", cyc, 32'd33);
    chk("op30_sig", sig30, 32'h8000_0000);
    chk("op30_last_op", {27'd0, op30}, 32'd30);
    tick();
`ifdef ALU_BIST_CMP_EN
    chk("op30_pass", {31'd0, pass30}, 32'd1);
`else
    chk("op30_pass", {31'd0, pass30}, 32'd0);
`endif

    use_real  = 1'b1;
    src0_init = 32'h8000_ffff;
    src1_init = 32'h0000_0001;
    exp_sig   = model_sig(32, src0_init, src1_init, 1'b1);
    do_sweep("real", 1'b0);
    use_real  = 1'b0;

    // abort on the 5th RUN cycle: four results compacted, then frozen
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort_op5", {27'd0, alu_op}, 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sig", signature, 32'h0000_0010);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("abort_sig_frozen", signature, 32'h0000_0010);
    chk("abort_pass", {31'd0, pass}, 32'd0);

    // abort outranks start in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", {31'd0, busy}, 32'd0);

    // async reset mid-sweep
    src0_init = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_op", {27'd0, alu_op}, 32'd0);
    chk("arst_src0", alu_src0, 32'd0);
    chk("arst_sig", signature, 32'd0);
    chk("arst_flags", {29'd0, busy, done, pass}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    exp_sig = 32'h0040_0007;
    do_sweep("restart", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
